ahb_word_copier: RTL
====================

# ahb_word_copier

AHB-Lite initiator (bus master) that copies a block of 32-bit words from a source address range to a destination address range, one single transfer at a time. It sits on the master side of the AHB-Lite interconnect, alongside the processor, and reaches the same memory-mapped slaves the processor uses, such as on-chip memory and the switch and LED peripherals. Local control logic launches a copy with a start pulse, and the block reports completion and bus errors back to it.

## Interface
- LEN_W, default 16, width of the word-count input and of the internal down-counter.
- HCLK  in  1  system clock; all logic on the rising edge.
- HRESET  in  1  synchronous, active-high reset.
- start  in  1  launch request; sampled only in IDLE.
- src_addr  in  32  source byte address; bits [1:0] are ignored and forced to 0.
- dst_addr  in  32  destination byte address; bits [1:0] are ignored and forced to 0.
- len_words  in  LEN_W  number of words to copy.
- busy  out  1  high from the cycle after an accepted start through the DONE cycle.
- done  out  1  one-cycle completion pulse, covering both success and error.
- error  out  1  sticky error flag; set on an HRESP error, cleared by the next accepted start.
- HADDR  out  32  AHB address.
- HTRANS  out  2  only IDLE (2'b00) or NONSEQ (2'b10).
- HWRITE  out  1  AHB write strobe.
- HSIZE  out  3  constant 3'b010 (word).
- HBURST  out  3  constant 3'b000 (SINGLE).
- HPROT  out  4  constant 4'b0011.
- HWDATA  out  32  write data.
- HRDATA  in  32  read data.
- HREADY  in  1  transfer-done signal from the interconnect.
- HRESP  in  1  slave error response.

## Operation
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, DONE.
- IDLE:
  - HTRANS=IDLE, HADDR=0, HWRITE=0.
  - start=1 with len_words≠0: latch the pointers (src_ptr, dst_ptr) and the count into cnt, clear error, go to RD_ADDR.
  - start=1 with len_words=0: clear error, go to DONE; no bus activity.
- RD_ADDR: drive HADDR=src_ptr, HTRANS=NONSEQ, HWRITE=0; at an edge with HREADY=1, go to RD_DATA. While HREADY=0, hold all address/control outputs stable.
- RD_DATA: HTRANS=IDLE; at an edge with HREADY=1:
  - HRESP=1: set error, go to DONE.
  - otherwise: capture HRDATA into the data register, go to WR_ADDR.
- WR_ADDR: drive HADDR=dst_ptr, HTRANS=NONSEQ, HWRITE=1; at an edge with HREADY=1, go to WR_DATA.
- WR_DATA: HTRANS=IDLE, HWDATA=data register (stable for the whole data phase); at an edge with HREADY=1:
  - HRESP=1: set error, go to DONE.
  - otherwise: src_ptr+=4, dst_ptr+=4, cnt-=1; go to DONE if cnt was 1, else go to RD_ADDR.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- Arithmetic:
  - Pointers are 32-bit and wrap modulo 2^32 (0xFFFF_FFFC+4 → 0x0000_0000).
  - cnt is LEN_W bits and never decrements below 1 inside the loop.
- HTRANS, HADDR and HWRITE are functions of registered state only; there is no combinational path from HREADY or HRESP to any output.
- A start while busy=1 is ignored and does not disturb the copy in progress.
- The HRESP two-cycle error response is handled naturally: the FSM already drives IDLE in the data phase and acts only when HREADY=1.

## Timing
- Reset (HRESET=1 at an edge) forces, from the next cycle:
  - state IDLE;
  - HTRANS=00, HADDR=0, HWRITE=0, HWDATA=0;
  - busy=0, done=0, error=0;
  - HSIZE, HBURST and HPROT at their constants.
- Reset mid-transfer abandons the copy immediately. No done pulse is generated, and the bus shows IDLE from the next cycle.
- With zero wait states, each word takes exactly 4 cycles (RD_ADDR, RD_DATA, WR_ADDR, WR_DATA).
- Cycle accounting, with start sampled at edge 0:
  - RD_ADDR occupies cycle 1;
  - done is high in cycle 4N+1;
  - busy is high in cycles 1..4N+1.
- Each wait cycle (HREADY=0) in any address or data phase adds exactly one cycle.
- len_words=0: done is high in cycle 1 and busy is high in cycle 1 only.
- After an error, done arrives in the cycle following the HREADY=1 edge of the failing data phase. error stays high until the next accepted start.

## Test plan
- Reset, then release: all outputs at reset values, HTRANS=00 for 10 cycles with no start → no NONSEQ ever driven.
- src=0x2000_0000, dst=0x2000_0100, len=1, zero-wait slave returning 0xDEADBEEF:
  - read at 0x2000_0000 in cycle 1;
  - write at 0x2000_0100 in cycle 3, HWDATA=0xDEADBEEF in cycle 4;
  - done in cycle 5, error=0.
- len=3 with two wait cycles inserted in each RD_DATA phase → 3 words copied in order at +0/+4/+8; done in cycle 19; address/control held stable during waits.
- len=0 → done pulse in cycle 1, no NONSEQ, busy high for one cycle only.
- Error case, len=4, slave error (HRESP=1 held through the two-cycle response) on the second read:
  - exactly one write completed;
  - error=1 and done pulse immediately after;
  - next start clears error.
- Edge cases:
  - src=0xFFFF_FFFC, len=2 → second read at 0x0000_0000;
  - start pulsed mid-copy → ignored, copy unaffected;
  - HRESET asserted in WR_ADDR → HTRANS=00 next cycle, no done pulse.

Source files
------------

// File: rtl/ahb_word_copier.sv
// AHB-Lite bus master that copies len_words 32-bit words from src_addr to dst_addr
// using one SINGLE read followed by one SINGLE write per word.
module ahb_word_copier #(
    parameter int unsigned LEN_W = 16
) (
    input  logic             HCLK,
    input  logic             HRESET,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len_words,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [31:0]      HADDR,
    output logic [1:0]       HTRANS,
    output logic             HWRITE,
    output logic [2:0]       HSIZE,
    output logic [2:0]       HBURST,
    output logic [3:0]       HPROT,
    output logic [31:0]      HWDATA,
    input  logic [31:0]      HRDATA,
    input  logic             HREADY,
    input  logic             HRESP
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ADDR,
        S_RD_DATA,
        S_WR_ADDR,
        S_WR_DATA,
        S_DONE
    } state_t;

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;

    state_t           state_q, state_d;
    logic [31:0]      src_ptr_q, src_ptr_d;
    logic [31:0]      dst_ptr_q, dst_ptr_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [31:0]      data_q, data_d;
    logic             error_q, error_d;
    logic [1:0]       htrans_q, htrans_d;
    logic [31:0]      haddr_q, haddr_d;
    logic             hwrite_q, hwrite_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_comb begin
        state_d   = state_q;
        src_ptr_d = src_ptr_q;
        dst_ptr_d = dst_ptr_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        error_d   = error_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    error_d = 1'b0;
                    if (len_words != '0) begin
                        src_ptr_d = {src_addr[31:2], 2'b00};
                        dst_ptr_d = {dst_addr[31:2], 2'b00};
                        cnt_d     = len_words;
                        state_d   = S_RD_ADDR;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_RD_ADDR: begin
                if (HREADY) state_d = S_RD_DATA;
            end
            S_RD_DATA: begin
                if (HREADY) begin
                    if (HRESP) begin
                        error_d = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        data_d  = HRDATA;
                        state_d = S_WR_ADDR;
                    end
                end
            end
            S_WR_ADDR: begin
                if (HREADY) state_d = S_WR_DATA;
            end
            S_WR_DATA: begin
                if (HREADY) begin
                    if (HRESP) begin
                        error_d = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        src_ptr_d = src_ptr_q + 32'd4;
                        dst_ptr_d = dst_ptr_q + 32'd4;
                        cnt_d     = cnt_q - LEN_W'(1);
                        state_d   = (cnt_q == LEN_W'(1)) ? S_DONE : S_RD_ADDR;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Bus outputs are decoded from the next state so they leave straight from flops.
        htrans_d = TRANS_IDLE;
        haddr_d  = '0;
        hwrite_d = 1'b0;
        if (state_d == S_RD_ADDR) begin
            htrans_d = TRANS_NONSEQ;
            haddr_d  = src_ptr_d;
        end else if (state_d == S_WR_ADDR) begin
            htrans_d = TRANS_NONSEQ;
            haddr_d  = dst_ptr_d;
            hwrite_d = 1'b1;
        end
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q   <= S_IDLE;
            src_ptr_q <= '0;
            dst_ptr_q <= '0;
            cnt_q     <= '0;
            data_q    <= '0;
            error_q   <= 1'b0;
            htrans_q  <= TRANS_IDLE;
            haddr_q   <= '0;
            hwrite_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            src_ptr_q <= src_ptr_d;
            dst_ptr_q <= dst_ptr_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            error_q   <= error_d;
            htrans_q  <= htrans_d;
            haddr_q   <= haddr_d;
            hwrite_q  <= hwrite_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign HTRANS = htrans_q;
    assign HADDR  = haddr_q;
    assign HWRITE = hwrite_q;
    assign HWDATA = data_q;
    assign HSIZE  = 3'b010;
    assign HBURST = 3'b000;
    assign HPROT  = 4'b0011;
    assign busy   = busy_q;
    assign done   = done_q;
    assign error  = error_q;

endmodule
